conv_acc_seq: RTL and testbench

//  Top-level sequencer for the conv accelerator datapath (3x3 conv -> feature map -> 10-class FC).

---
 rtl/conv_acc_seq.sv | 156 +++++++++++++++
 tb/tb_conv_acc_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_seq.sv
// Job sequencer for the conv -> feature map -> FC datapath.
// Emits enables, addresses and clears; holds no arithmetic.
module conv_acc_seq #(
  parameter int IMG_W    = 28,
  parameter int K        = 3,
  parameter int CONV_LAT = 2,
  parameter int FC_LAT   = 3,
  parameter int AW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pre_valid,
  output logic          o_pre_ready,
  output logic          o_post_valid,
  input  logic          i_post_ready,
  output logic          o_conv_en,
  output logic [4:0]    o_win_row,
  output logic [4:0]    o_win_col,
  output logic          o_fmap_we,
  output logic [AW-1:0] o_fmap_waddr,
  output logic          o_fc_clr,
  output logic          o_fc_en,
  output logic [AW-1:0] o_fc_idx,
  output logic          o_busy
);

  localparam int OUT_W  = IMG_W - K + 1;
  localparam int N_FEAT = OUT_W * OUT_W;

  localparam logic [4:0]    LAST_W = 5'(OUT_W - 1);
  localparam logic [AW-1:0] LAST_F = AW'(N_FEAT - 1);
  localparam logic [2:0]    CD_END = 3'(CONV_LAT - 1);
  localparam logic [2:0]    FD_END = 3'(FC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_CDRAIN,
    S_FC,
    S_FDRAIN,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [4:0]          row;
  logic [4:0]          col;
  logic [AW-1:0]       idx;
  logic [AW-1:0]       waddr;
  logic [2:0]          dcnt;
  logic [CONV_LAT-1:0] we_sr;
  logic                clr;

  logic accept;
  logic conv_done;
  logic fc_done;
  logic in_drain;

  assign accept    = (state == S_IDLE) && i_pre_valid;
  assign conv_done = (row == LAST_W) && (col == LAST_W);
  assign fc_done   = (idx == LAST_F);
  assign in_drain  = (state == S_CDRAIN) || (state == S_FDRAIN);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt    = state;
    o_pre_ready  = 1'b0;
    o_conv_en    = 1'b0;
    o_fc_en      = 1'b0;
    o_post_valid = 1'b0;
    o_busy       = 1'b1;
    unique case (state)
      S_IDLE: begin
        o_pre_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_pre_valid) state_nxt = S_CONV;
      end
      S_CONV: begin
        o_conv_en = 1'b1;
        if (conv_done) state_nxt = S_CDRAIN;
      end
      S_CDRAIN: begin
        if (dcnt == CD_END) state_nxt = S_FC;
      end
      S_FC: begin
        o_fc_en = 1'b1;
        if (fc_done) state_nxt = S_FDRAIN;
      end
      S_FDRAIN: begin
        if (dcnt == FD_END) state_nxt = S_OUT;
      end
      S_OUT: begin
        o_post_valid = 1'b1;
        if (i_post_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window raster walk; wraps to (0,0) after the last window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      row <= '0;
      col <= '0;
    end else if (state == S_CONV) begin
      if (col == LAST_W) begin
        col <= '0;
        row <= (row == LAST_W) ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

  // Conv result valid pipe and fmap write address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_sr <= '0;
      waddr <= '0;
    end else begin
      we_sr <= (we_sr << 1) | CONV_LAT'(state == S_CONV);
      if (o_fmap_we) waddr <= (waddr == LAST_F) ? '0 : waddr + 1'b1;
    end
  end

  // FC feature index, drain counter and one-shot clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx  <= '0;
      dcnt <= '0;
      clr  <= 1'b0;
    end else begin
      clr  <= accept;
      dcnt <= (in_drain && state_nxt == state) ? dcnt + 3'd1 : 3'd0;
      if (state == S_FC) idx <= fc_done ? '0 : idx + 1'b1;
    end
  end

  assign o_win_row    = row;
  assign o_win_col    = col;
  assign o_fmap_we    = we_sr[CONV_LAT-1];
  assign o_fmap_waddr = waddr;
  assign o_fc_clr     = clr;
  assign o_fc_idx     = idx;

endmodule

// File: tb/tb_conv_acc_seq.sv
// Directed bench for conv_acc_seq: default latencies on one
// instance, CONV_LAT=FC_LAT=1 on a second.
module tb_conv_acc_seq;

  localparam int N = 676;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre_valid = 1'b0;
  logic post_ready = 1'b0;
  logic sel = 1'b0;

  int checks = 0;
  int failures = 0;

  logic       a_pre_ready, a_post_valid, a_conv_en, a_fmap_we;
  logic       a_fc_clr, a_fc_en, a_busy;
  logic [4:0] a_row, a_col;
  logic [9:0] a_waddr, a_idx;
  logic       b_pre_ready, b_post_valid, b_conv_en, b_fmap_we;
  logic       b_fc_clr, b_fc_en, b_busy;
  logic [4:0] b_row, b_col;
  logic [9:0] b_waddr, b_idx;

  always #5 clk = ~clk;

  conv_acc_seq u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pre_valid(pre_valid & ~sel), .o_pre_ready(a_pre_ready),
    .o_post_valid(a_post_valid), .i_post_ready(post_ready),
    .o_conv_en(a_conv_en), .o_win_row(a_row), .o_win_col(a_col),
    .o_fmap_we(a_fmap_we), .o_fmap_waddr(a_waddr),
    .o_fc_clr(a_fc_clr), .o_fc_en(a_fc_en), .o_fc_idx(a_idx),
    .o_busy(a_busy)
  );

  conv_acc_seq #(.CONV_LAT(1), .FC_LAT(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pre_valid(pre_valid & sel), .o_pre_ready(b_pre_ready),
    .o_post_valid(b_post_valid), .i_post_ready(post_ready),
    .o_conv_en(b_conv_en), .o_win_row(b_row), .o_win_col(b_col),
    .o_fmap_we(b_fmap_we), .o_fmap_waddr(b_waddr),
    .o_fc_clr(b_fc_clr), .o_fc_en(b_fc_en), .o_fc_idx(b_idx),
    .o_busy(b_busy)
  );

  logic       m_pre_ready, m_post_valid, m_conv_en, m_fmap_we;
  logic       m_fc_clr, m_fc_en, m_busy;
  logic [4:0] m_row, m_col;
  logic [9:0] m_waddr, m_idx;

  assign m_pre_ready  = sel ? b_pre_ready  : a_pre_ready;
  assign m_post_valid = sel ? b_post_valid : a_post_valid;
  assign m_conv_en    = sel ? b_conv_en    : a_conv_en;
  assign m_fmap_we    = sel ? b_fmap_we    : a_fmap_we;
  assign m_fc_clr     = sel ? b_fc_clr     : a_fc_clr;
  assign m_fc_en      = sel ? b_fc_en      : a_fc_en;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_row        = sel ? b_row        : a_row;
  assign m_col        = sel ? b_col        : a_col;
  assign m_waddr      = sel ? b_waddr      : a_waddr;
  assign m_idx        = sel ? b_idx        : a_idx;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pre_ready"}, int'(m_pre_ready), 1);
    check({tag, "_busy"}, int'(m_busy), 0);
    check({tag, "_enables"},
          int'({m_conv_en, m_fmap_we, m_fc_en, m_fc_clr}), 0);
    check({tag, "_post_valid"}, int'(m_post_valid), 0);
    check({tag, "_ctrs"},
          int'({m_row, m_col, m_waddr, m_idx}), 0);
  endtask

  // Accept one job, watch it to the result handshake, check timing.
  task automatic run_job(input int clat, input int flat,
                         input int hold, input bit keep);
    int t = 0;
    int conv_first = -1, conv_last = -1, conv_cnt = 0;
    int we_first = -1, we_last = -1, we_cnt = 0;
    int fc_first = -1, fc_last = -1, fc_cnt = 0;
    int clr_cnt = 0, clr_cyc = -1;
    int post_first = -1, vcnt = 0;
    int raster_err = 0, addr_err = 0, idx_err = 0;
    int overlap = 0, busy_err = 0, early = 0;
    int end_ready = 0;
    bit done = 0;
    while (!m_pre_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", int'(m_pre_ready), 1);
    post_ready = (hold == 0);
    pre_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3000 && !done; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) pre_valid = 1'b0;
      if (m_post_valid) begin
        if (post_first < 0) post_first = k;
        vcnt++;
        if (m_pre_ready || m_conv_en) early++;
        if (vcnt == hold + 1) post_ready = 1'b1;
      end else if (vcnt > 0) begin
        done = 1;
        end_ready = int'(m_pre_ready);
      end
      if (!done && !m_busy) busy_err++;
      if (m_conv_en) begin
        if (conv_first < 0) conv_first = k;
        conv_last = k;
        if (m_row != 5'(conv_cnt / 26) || m_col != 5'(conv_cnt % 26))
          raster_err++;
        conv_cnt++;
      end
      if (k == 26) check("raster_26", int'({m_row, m_col}), (0 << 5) | 25);
      if (k == 27) check("raster_27", int'({m_row, m_col}), (1 << 5) | 0);
      if (k == N) check("raster_676", int'({m_row, m_col}), (25 << 5) | 25);
      if (m_fmap_we) begin
        if (we_first < 0) we_first = k;
        we_last = k;
        if (int'(m_waddr) != we_cnt) addr_err++;
        we_cnt++;
      end
      if (m_fc_en) begin
        if (fc_first < 0) fc_first = k;
        fc_last = k;
        if (int'(m_idx) != fc_cnt) idx_err++;
        fc_cnt++;
      end
      if (m_fc_clr) begin
        clr_cnt++;
        clr_cyc = k;
      end
      if ((m_conv_en && m_fc_en) || (m_fmap_we && m_fc_en)) overlap++;
    end
    check("job_done", int'(done), 1);
    check("conv_first", conv_first, 1);
    check("conv_last", conv_last, N);
    check("conv_cnt", conv_cnt, N);
    check("raster_err", raster_err, 0);
    check("we_first", we_first, 1 + clat);
    check("we_last", we_last, N + clat);
    check("addr_err", addr_err, 0);
    check("fc_first", fc_first, N + clat + 1);
    check("fc_last", fc_last, 2 * N + clat);
    check("idx_err", idx_err, 0);
    check("clr_cnt", clr_cnt, 1);
    check("clr_cyc", clr_cyc, 1);
    check("overlap", overlap, 0);
    check("busy_err", busy_err, 0);
    check("post_first", post_first, 2 * N + clat + flat + 1);
    check("valid_len", vcnt, hold + 1);
    check("early_accept", early, 0);
    check("ready_after", end_ready, 1);
  endtask

  initial begin
    sel = 1'b0;
    #13;
    check_idle("rst_a");
    sel = 1'b1;
    #1;
    check_idle("rst_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(2, 3, 0, 1'b0);

    run_job(2, 3, 20, 1'b1);
    run_job(2, 3, 0, 1'b0);

    pre_valid = 1'b1;
    post_ready = 1'b1;
    @(posedge clk);
    #1 pre_valid = 1'b0;
    repeat (699) @(posedge clk);
    #1;
    check("fc_before_rst", int'(m_fc_en), 1);
    #1 rst_n = 1'b0;
    #1;
    check_idle("midjob_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(2, 3, 0, 1'b0);

    sel = 1'b1;
    @(negedge clk);
    run_job(1, 1, 0, 1'b1);
    run_job(1, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
